// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader
//   Host-side job loader for the pipelined cpu. Accepts a program image on a
//   valid/ready stream (header, run_cycles, imem payload, dmem payload),
//   writes it into the cpu's external memory ports while holding the cpu in
//   reset, releases the cpu for run_cycles cycles, then streams data memory
//   back to the host.
//
//   Optional build macro: LOADER_CHECKSUM_EN
//     Adds a CHK state after the payload that accepts one trailer word equal
//     to the wrapping 32-bit sum of all payload words; a mismatch goes to ERR.
//
// Ports
//   clk, arst              clock, asynchronous active-high reset
//   s_valid/s_ready/s_data host input stream (header, run_cycles, payload)
//   m_valid/m_ready/m_data/m_last  dump stream of data memory to the host
//   busy, done, err        job status (done is a one-cycle pulse, err sticky)
//   cpu_enable, cpu_arst_n cpu run control
//   imem_addr/wen/wdata    instruction-memory write port
//   dmem_addr/wen/ren/wdata/rdata  data-memory port (rdata one cycle after ren)
module cpu_mem_loader #(
  parameter int unsigned IMEM_DEPTH  = 512,
  parameter int unsigned DMEM_DEPTH  = 1024,
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_enable,
  output logic        cpu_arst_n,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic        dmem_ren,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR1,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_CAP,
    S_DUMP_OUT,
    S_FIN,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] n_imem_q, n_dmem_q;
  logic [15:0] idx_q;
  logic [31:0] run_cnt_q;
  logic [31:0] m_data_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  logic        hs;
  logic        hdr_bad;
  logic        last_i, last_d;
  logic [31:0] idx_addr;
  state_t      after_load;

  assign hs       = s_valid && s_ready;
  assign hdr_bad  = (s_data[15:0] == 16'd0)
                 || (32'(s_data[15:0])  > IMEM_DEPTH)
                 || (32'(s_data[31:16]) > DMEM_DEPTH);
  assign last_i   = (idx_q == n_imem_q - 16'd1);
  assign last_d   = (idx_q == n_dmem_q - 16'd1);
  assign idx_addr = 32'(idx_q) * ADDR_STRIDE;
  assign m_data   = m_data_q;

`ifdef LOADER_CHECKSUM_EN
  assign after_load = S_CHK;
`else
  assign after_load = S_RUN;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    cpu_enable = 1'b0;
    cpu_arst_n = 1'b0;
    imem_addr  = '0;
    imem_wen   = 1'b0;
    imem_wdata = '0;
    dmem_addr  = '0;
    dmem_wen   = 1'b0;
    dmem_ren   = 1'b0;
    dmem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        busy    = 1'b0;
        s_ready = 1'b1;
        if (hs) state_d = hdr_bad ? S_ERR : S_HDR1;
      end
      S_HDR1: begin
        s_ready = 1'b1;
        if (hs) state_d = S_LOAD_I;
      end
      S_LOAD_I: begin
        s_ready    = 1'b1;
        imem_wen   = s_valid;
        imem_addr  = idx_addr;
        imem_wdata = s_data;
        if (hs && last_i) state_d = (n_dmem_q != 16'd0) ? S_LOAD_D : after_load;
      end
      S_LOAD_D: begin
        s_ready    = 1'b1;
        dmem_wen   = s_valid;
        dmem_addr  = idx_addr;
        dmem_wdata = s_data;
        if (hs && last_d) state_d = after_load;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        s_ready = 1'b1;
        if (hs) state_d = (s_data == sum_q) ? S_RUN : S_ERR;
      end
`endif
      S_RUN: begin
        cpu_arst_n = 1'b1;
        cpu_enable = (run_cnt_q != 32'd0);
        // Leaving on the count of 1 gives exactly run_cycles enabled cycles;
        // a zero count still spends one (disabled) cycle here.
        if (run_cnt_q <= 32'd1) state_d = (n_dmem_q != 16'd0) ? S_DUMP_RD : S_FIN;
      end
      S_DUMP_RD: begin
        cpu_arst_n = 1'b1;
        dmem_ren   = 1'b1;
        dmem_addr  = idx_addr;
        state_d    = S_DUMP_CAP;
      end
      S_DUMP_CAP: begin
        cpu_arst_n = 1'b1;
        state_d    = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        cpu_arst_n = 1'b1;
        m_valid    = 1'b1;
        m_last     = last_d;
        if (m_ready) state_d = last_d ? S_FIN : S_DUMP_RD;
      end
      S_FIN: begin
        cpu_arst_n = 1'b1;
        done       = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      n_imem_q  <= '0;
      n_dmem_q  <= '0;
      idx_q     <= '0;
      run_cnt_q <= '0;
      m_data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (hs) begin
          n_imem_q <= s_data[15:0];
          n_dmem_q <= s_data[31:16];
          idx_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
          sum_q    <= '0;
`endif
        end
        S_HDR1: if (hs) run_cnt_q <= s_data;
        S_LOAD_I: if (hs) begin
          idx_q <= last_i ? 16'd0 : idx_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_q <= sum_q + s_data;
`endif
        end
        S_LOAD_D: if (hs) begin
          idx_q <= last_d ? 16'd0 : idx_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_q <= sum_q + s_data;
`endif
        end
        S_RUN: if (run_cnt_q != 32'd0) run_cnt_q <= run_cnt_q - 32'd1;
        S_DUMP_CAP: m_data_q <= dmem_rdata;
        S_DUMP_OUT: if (m_ready) idx_q <= last_d ? 16'd0 : idx_q + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
module tb_cpu_mem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy, done, err, cpu_enable, cpu_arst_n;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic        imem_wen, dmem_wen, dmem_ren;
  logic [31:0] dmem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cpu_mem_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024), .ADDR_STRIDE(4)) dut (
    .clk(clk), .arst(arst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err),
    .cpu_enable(cpu_enable), .cpu_arst_n(cpu_arst_n),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  // Stand-in for the cpu's memories and activity counters.
  logic [31:0] mem [0:1023];
  logic [31:0] ia[$], id[$], da[$], dd[$];
  int ren_cnt = 0, en_cnt = 0, done_cnt = 0;

  always @(posedge clk) begin
    if (imem_wen) begin ia.push_back(imem_addr); id.push_back(imem_wdata); end
    if (dmem_wen) begin
      da.push_back(dmem_addr); dd.push_back(dmem_wdata);
      mem[dmem_addr[11:2]] <= dmem_wdata;
    end
    if (dmem_ren) begin ren_cnt++; dmem_rdata <= mem[dmem_addr[11:2]]; end
    if (cpu_enable) en_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  // Called at a negedge; the word transfers on the next posedge.
  task automatic send(input logic [31:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic trailer(input logic [31:0] w);
    if (CHK_EN) send(w);
  endtask

  task automatic rst_pulse();
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic wait_mvalid(input string tag);
    for (int i = 0; i < 20 && !m_valid; i++) @(negedge clk);
    chk(tag, m_valid, 1'b1);
  endtask

  task automatic hdr_probe(input string tag, input logic [31:0] w, input logic bad);
    send(w);
    chk(tag, err, bad);
    chk(tag, busy, !bad);
    rst_pulse();
  endtask

  int ib, db, e0, d0, r0, c, unstable;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_cpu_arst_n", cpu_arst_n, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_wen", {imem_wen, dmem_wen, dmem_ren, cpu_enable}, 4'b0);
    chk("rst_addr", imem_addr | dmem_addr, 32'd0);
    arst = 1'b0;
    @(negedge clk);

    // Job 1: 3 imem, 2 dmem, run_cycles 0, dump with a 10-cycle stall
    ib = ia.size(); db = da.size(); e0 = en_cnt; d0 = done_cnt; r0 = ren_cnt;
    send(32'h0002_0003);
    chk("j1_busy", busy, 1'b1);
    send(32'd0);
    send(32'hA); send(32'hB); send(32'hC);
    send(32'h11); send(32'h22);
    trailer(32'h54);
    chk("j1_imem_n", ia.size() - ib, 3);
    chk("j1_imem_a0", ia[ib], 32'd0);
    chk("j1_imem_a1", ia[ib+1], 32'd4);
    chk("j1_imem_a2", ia[ib+2], 32'd8);
    chk("j1_imem_d2", id[ib+2], 32'hC);
    chk("j1_dmem_n", da.size() - db, 2);
    chk("j1_dmem_a1", da[db+1], 32'd4);
    chk("j1_dmem_d1", dd[db+1], 32'h22);
    chk("j1_run_state", {cpu_arst_n, cpu_enable}, 2'b10);
    wait_mvalid("j1_mv0");
    chk("j1_m_data0", m_data, 32'h11);
    chk("j1_m_last0", m_last, 1'b0);
    chk("j1_cpu_arst_n_dump", cpu_arst_n, 1'b1);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!m_valid || m_data !== 32'h11) unstable++;
    end
    chk("j1_stall_stable", unstable, 0);
    chk("j1_stall_ren", ren_cnt - r0, 1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("j1_mv_drop", m_valid, 1'b0);
    wait_mvalid("j1_mv1");
    chk("j1_m_data1", m_data, 32'h22);
    chk("j1_m_last1", m_last, 1'b1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("j1_done", done, 1'b1);
    @(negedge clk);
    chk("j1_idle", {busy, done, cpu_arst_n, s_ready}, 4'b0001);
    chk("j1_done_cnt", done_cnt - d0, 1);
    chk("j1_en_cnt", en_cnt - e0, 0);
    chk("j1_ren_cnt", ren_cnt - r0, 2);

    // Job 2: 1 imem, no dmem, run_cycles 5
    e0 = en_cnt; r0 = ren_cnt; d0 = done_cnt;
    send(32'h0000_0001);
    send(32'd5);
    chk("j2_arst_n_load", cpu_arst_n, 1'b0);
    send(32'h1234);
    trailer(32'h1234);
    chk("j2_arst_n_run", cpu_arst_n, 1'b1);
    chk("j2_enable", cpu_enable, 1'b1);
    c = 0;
    while (!done && c < 50) begin @(negedge clk); c++; end
    chk("j2_run_len", c, 5);
    chk("j2_en_cnt", en_cnt - e0, 5);
    @(negedge clk);
    chk("j2_idle", {busy, cpu_arst_n, m_valid}, 3'b000);
    chk("j2_no_dump", ren_cnt - r0, 0);
    chk("j2_done_cnt", done_cnt - d0, 1);

    // Bad header n_imem=513: sticky error, nothing written
    ib = ia.size(); db = da.size(); e0 = en_cnt;
    send(32'h0000_0201);
    chk("err_err", err, 1'b1);
    chk("err_s_ready", s_ready, 1'b0);
    chk("err_busy", busy, 1'b0);
    s_valid = 1'b1; s_data = 32'h0000_0001;
    repeat (5) @(negedge clk);
    s_valid = 1'b0;
    chk("err_sticky", err, 1'b0 ^ 1'b1);
    chk("err_no_wen", (ia.size() - ib) + (da.size() - db) + (en_cnt - e0), 0);
    chk("err_arst_n", cpu_arst_n, 1'b0);
    rst_pulse();
    chk("err_cleared", {err, s_ready}, 2'b01);

    // Header boundaries
    hdr_probe("hdr_imem0", 32'h0000_0000, 1'b1);
    hdr_probe("hdr_dmem1025", 32'h0401_0001, 1'b1);
    hdr_probe("hdr_max_ok", 32'h0400_0200, 1'b0);

    // Reset mid LOAD_I after 2 words, then a fresh job
    ib = ia.size();
    send(32'h0001_0004);
    send(32'd3);
    send(32'h100); send(32'h200);
    chk("abort_imem_n", ia.size() - ib, 2);
    arst = 1'b1;
    @(negedge clk);
    chk("abort_outs", {s_ready, busy, done, err, cpu_arst_n, cpu_enable, imem_wen, m_valid}, 8'b1000_0000);
    arst = 1'b0;
    @(negedge clk);
    ib = ia.size(); e0 = en_cnt;
    send(32'h0001_0001);
    send(32'd2);
    send(32'h55);
    send(32'h77);
    trailer(32'hCC);
    chk("abort_new_imem", ia[ib], 32'd0);
    chk("abort_new_imem_d", id[ib], 32'h55);
    wait_mvalid("abort_mv");
    chk("abort_m_data", m_data, 32'h77);
    chk("abort_m_last", m_last, 1'b1);
    chk("abort_en_cnt", en_cnt - e0, 2);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("abort_done", done, 1'b1);
    @(negedge clk);

    if (CHK_EN) begin
      send(32'h0000_0003);
      send(32'd0);
      send(32'd1); send(32'd2); send(32'd3);
      send(32'd6);
      chk("cks_ok_run", {cpu_arst_n, err}, 2'b10);
      for (int i = 0; i < 10 && !done; i++) @(negedge clk);
      chk("cks_ok_done", done, 1'b1);
      @(negedge clk);
      send(32'h0000_0003);
      send(32'd0);
      send(32'd1); send(32'd2); send(32'd3);
      send(32'd7);
      chk("cks_bad_err", err, 1'b1);
      @(negedge clk);
      chk("cks_bad_arst_n", cpu_arst_n, 1'b0);
      rst_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
